// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with single-outstanding IMEM request and IF/ID register
//
// Purpose: issues one instruction-memory read at a time, tracks the fetch PC,
//          handles execute-stage redirects, buffers a response that arrives
//          while decode is stalled, and maintains the IF/ID pipeline register.
// Optional feature: define FETCH_PERF_CNT_EN to add FetchCount / RedirectCount.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   PCSrcE, PCTargetE       redirect request and target from execute
//   StallD, FlushD          decode stall / flush controls for IF/ID
//   IMemReq, IMemAddr       one-cycle read request pulse and address
//   IMemRdata, IMemValid    read response data and strobe
//   PCF                     current fetch PC
//   InstrD, PCD, PCPlus4D   IF/ID register contents
//   ValidD                  IF/ID holds a real instruction
//   FetchCount, RedirectCount  (FETCH_PERF_CNT_EN only) wrapping event counters

module fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  PCSrcE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    input  logic                  StallD,
    input  logic                  FlushD,
    output logic                  IMemReq,
    output logic [DATA_WIDTH-1:0] IMemAddr,
    input  logic [DATA_WIDTH-1:0] IMemRdata,
    input  logic                  IMemValid,
    output logic [DATA_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [DATA_WIDTH-1:0] PCD,
    output logic [DATA_WIDTH-1:0] PCPlus4D,
`ifdef FETCH_PERF_CNT_EN
    output logic                  ValidD,
    output logic [31:0]           FetchCount,
    output logic [31:0]           RedirectCount
`else
    output logic                  ValidD
`endif
);

    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2,
        S_HELD  = 2'd3
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] skid;
    logic [DATA_WIDTH-1:0] target_al;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic                  load_en;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  unused_target_lsb;

    // Targets are word aligned; the low two bits are dropped.
    assign target_al         = {PCTargetE[DATA_WIDTH-1:2], 2'b00};
    assign unused_target_lsb = ^PCTargetE[1:0];
    assign pc_plus4          = PCF + DATA_WIDTH'(4);

    // Request is a pure function of state so it stays a one-cycle pulse; a
    // redirect arriving in the issue cycle is honoured without a lost cycle.
    assign IMemReq  = rst_n && (state == S_ISSUE);
    assign IMemAddr = (state == S_ISSUE && PCSrcE) ? target_al : PCF;

    // load_en marks the cycle in which a fetched word is consumed into IF/ID;
    // a concurrent FlushD still consumes it but writes a bubble instead.
    always_comb begin
        load_en   = 1'b0;
        load_data = skid;
        case (state)
            S_WAIT: begin
                if (!PCSrcE && IMemValid && !StallD) begin
                    load_en   = 1'b1;
                    load_data = IMemRdata;
                end
            end
            S_HELD: begin
                if (!PCSrcE && !StallD) begin
                    load_en = 1'b1;
                end
            end
            default: begin
                load_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_ISSUE;
            PCF   <= RESET_PC;
            skid  <= '0;
        end else begin
            case (state)
                S_ISSUE: begin
                    PCF   <= IMemAddr;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (PCSrcE) begin
                        PCF   <= target_al;
                        // Without the response yet, it must be drained in DROP.
                        state <= IMemValid ? S_ISSUE : S_DROP;
                    end else if (IMemValid) begin
                        if (load_en) begin
                            PCF   <= pc_plus4;
                            state <= S_ISSUE;
                        end else begin
                            skid  <= IMemRdata;
                            state <= S_HELD;
                        end
                    end
                end
                S_DROP: begin
                    if (PCSrcE) begin
                        PCF <= target_al;
                    end
                    if (IMemValid) begin
                        state <= S_ISSUE;
                    end
                end
                S_HELD: begin
                    if (PCSrcE) begin
                        PCF   <= target_al;
                        state <= S_ISSUE;
                    end else if (load_en) begin
                        PCF   <= pc_plus4;
                        state <= S_ISSUE;
                    end
                end
                default: begin
                    state <= S_ISSUE;
                end
            endcase
        end
    end

    // IF/ID register: flush beats stall beats load; otherwise a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            InstrD   <= NOP;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD <= NOP;
            ValidD <= 1'b0;
        end else if (StallD) begin
            InstrD <= InstrD;
            ValidD <= ValidD;
        end else if (load_en) begin
            InstrD   <= load_data;
            PCD      <= PCF;
            PCPlus4D <= pc_plus4;
            ValidD   <= 1'b1;
        end else begin
            InstrD <= NOP;
            ValidD <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Counts only words that actually land in IF/ID, and every redirect,
    // since all states accept PCSrcE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            FetchCount    <= '0;
            RedirectCount <= '0;
        end else begin
            if (load_en && !FlushD) begin
                FetchCount <= FetchCount + 32'd1;
            end
            if (PCSrcE) begin
                RedirectCount <= RedirectCount + 32'd1;
            end
        end
    end
`endif

endmodule
